// File: rtl/wrbitreverse.sv
// Bit-reversal reorder buffer ahead of a DIT FFT: natural-order frames in,
// bit-reversed frames out, using ping-pong banks addressed by a reversed write counter.
module wrbitreverse #(
    parameter int LGSIZE = 5,
    parameter int WIDTH  = 24
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ce,
    input  logic               i_sync,
    input  logic [2*WIDTH-1:0] i_in,
    output logic [2*WIDTH-1:0] o_out,
    output logic               o_sync
);

    // state | meaning
    // IDLE  | waiting for the first i_sync; samples are discarded
    // FILL  | first bank being written; output data not yet valid
    // RUN   | steady ping-pong: one bank written while the other is read
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam int N = 1 << LGSIZE;

    state_t             state, state_nx;
    logic               wrbank, wrbank_nx;
    logic [LGSIZE-1:0]  wrcnt, wrcnt_nx;
    logic               restart, wr_en, sync_nx;
    logic [LGSIZE:0]    wr_addr, rd_addr;
    logic [2*WIDTH-1:0] mem [0:2*N-1];

    function automatic logic [LGSIZE-1:0] bitrev(input logic [LGSIZE-1:0] v);
        logic [LGSIZE-1:0] r;
        r = '0;
        for (int k = 0; k < LGSIZE; k++)
            r[k] = v[LGSIZE-1-k];
        return r;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            wrcnt  <= '0;
            wrbank <= 1'b0;
        end else if (i_ce) begin
            state  <= state_nx;
            wrcnt  <= wrcnt_nx;
            wrbank <= wrbank_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        wrcnt_nx  = wrcnt;
        wrbank_nx = wrbank;
        if (restart) begin
            state_nx  = FILL;
            wrcnt_nx  = LGSIZE'(1);
            wrbank_nx = 1'b0;
        end else if (state != IDLE) begin
            wrcnt_nx = wrcnt + LGSIZE'(1);
            if (wrcnt == '1) begin
                wrbank_nx = !wrbank;
                if (state == FILL)
                    state_nx = RUN;
            end
        end
    end

    // A sync in IDLE, or one landing mid-frame, starts a fresh frame in bank 0.
    always_comb begin
        restart = i_sync && ((state == IDLE) || (wrcnt != '0));
        wr_en   = i_ce && ((state != IDLE) || i_sync);
        wr_addr = restart ? '0 : {wrbank, bitrev(wrcnt)};
        rd_addr = {!wrbank, wrcnt};
        sync_nx = (state == RUN) && (wrcnt == '0) && !restart;
    end

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_addr] <= i_in;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_out  <= '0;
            o_sync <= 1'b0;
        end else if (i_ce) begin
            o_out  <= mem[rd_addr];
            o_sync <= sync_nx;
        end
    end

endmodule

// File: doc/wrbitreverse.md
# wrbitreverse

Input-side bit-reversal reorder buffer for the pipelined FFT. It accepts a natural-order, sync-framed sample stream (`i_sync` marks sample 0 of each frame) and emits each frame in bit-reversed order with an `o_sync` pulse on the first output sample. It is the consumer of a framing sync rather than its producer: reversal happens on the write address, and reads are sequential. It sits ahead of a decimation-in-time (DIT) FFT/IFFT core, which expects bit-reversed input.

## Interface
- `LGSIZE`, 5: log2 of the frame size; N = 2^LGSIZE.
- `WIDTH`, 24: width of each real/imag component; samples are 2*WIDTH bits.
- `i_clk` input 1: clock; all logic is on the rising edge.
- `i_reset` input 1: reset, asynchronous and active-high.
- `i_ce` input 1: clock enable; one sample is accepted per cycle with `i_ce` high.
- `i_sync` input 1: qualified by `i_ce`; the current `i_in` is sample 0 of a frame.
- `i_in` input 2*WIDTH: input sample, {real, imag}.
- `o_out` output 2*WIDTH: reordered sample (registered).
- `o_sync` output 1: high with `o_out` when `o_out` is the first sample of a frame (registered).

## Operation
- Memory: 2^(LGSIZE+1) words of 2*WIDTH bits, used as two ping-pong banks of N words. It is not reset.
- Registers: `wrbank` (1 bit), `wrcnt[LGSIZE-1:0]`, and `state` ∈ {IDLE, FILL, RUN}.
- Write address: {`wrbank`, bitrev(`wrcnt`)}, where bitrev maps bit k to bit LGSIZE-1-k.
- Read address: {!`wrbank`, `wrcnt`}.
- Result: output index m of a frame equals input sample bitrev(m).
- Nothing changes on a cycle with `i_ce` low; all outputs hold.
- IDLE:
  - `i_ce` && !`i_sync`: the sample is discarded; no write; `wrcnt` holds.
  - `i_ce` && `i_sync`: write to {0,0}; `wrcnt`←1; `wrbank`←0; go to FILL.
- FILL and RUN, on `i_ce`:
  - Write `i_in` at the write address.
  - `wrcnt`←`wrcnt`+1.
  - On wrap (`wrcnt`==N-1): `wrbank` toggles; FILL goes to RUN.
- Aligned sync: `i_sync` with `wrcnt`==0 in FILL or RUN is normal operation; no action.
- Misaligned sync: `i_sync` with `wrcnt`!=0 in FILL or RUN restarts the frame.
  - The sample is written to {0,0}; `wrcnt`←1; `wrbank`←0; state←FILL.
  - The partially written frame is abandoned.
- Output, on every `i_ce`:
  - `o_out` ← mem[read address], in all states; data outside RUN is don't-care.
  - `o_sync` ← (state==RUN) && (`wrcnt`==0) && !(misaligned sync this cycle).
- Read and write always target opposite banks, so there is no read/write collision.

## Timing
- Reset (async, immediate, no clock edge needed):
  - `o_out`=0, `o_sync`=0, state=IDLE, `wrcnt`=0, `wrbank`=0.
  - Memory contents are retained but unused until refilled.
- Latency: input sample n of frame k (accepted at ce-count kN+n) belongs to output frame k.
  - That frame appears on `o_out` during ce-counts (k+1)N … (k+1)N+N-1, with output index bitrev(n).
  - `o_sync` is asserted after the edge with ce-count (k+1)N.
- `o_sync` is a single-ce pulse: exactly one per N `i_ce` cycles in steady RUN, never in IDLE or FILL.
- Throughput: one sample per `i_ce` cycle, sustained; no backpressure.
- Reset mid-frame: all in-flight frames are dropped; a fresh `i_sync` is required before output resumes.
- `i_sync` with `i_ce` low is ignored.

## Test plan
- LGSIZE=5, `i_ce`=1 continuously, `i_sync` on the first sample, `i_in`=n for n=0,1,2,…
  → `o_sync` first high after the edge accepting n=32.
  → `o_out` sequence 0,16,8,24,4,20,12,28,…,31.
  → The next frame is 32,48,40,…; `o_sync` repeats every 32 cycles.
- Same stimulus with `i_ce` high every 3rd cycle.
  → Identical `o_out`/`o_sync` sequence counted in ce cycles; outputs hold between enables.
- After reset, 10 samples with `i_sync`=0, then `i_sync` on value 100.
  → No `o_sync` for the first 41 ce cycles.
  → First `o_sync` after the ce accepting value 132, with `o_out`=100.
- Misaligned sync: aligned stream, then `i_sync` at n=40 (frame index 8).
  → No `o_sync` at n=64.
  → Next `o_sync` after the ce accepting n=72, with `o_out`=40, then 56, 48, …
- Assert `i_reset` asynchronously mid-frame in RUN.
  → `o_out`=0 and `o_sync`=0 before the next clock edge.
  → After release, outputs stay idle until `i_sync`; then the scenario 1 timing recurs.
- `i_sync` asserted on every 32nd sample (aligned) for 4 frames.
  → Output is identical to scenario 1; no restarts; exactly 3 `o_sync` pulses within 128 ce cycles.
